// File: rtl/parity_tx_ctrl.sv
// parity_tx_ctrl: framed LSB-first serial transmitter with an appended parity bit.
// Ports: clk, rst_n, s_data/s_valid/s_ready (word in), ser_data/ser_en/ser_last,
// busy, frame_done. Optional macro PARITY_TX_STOP_EN adds a trailing stop bit.
module parity_tx_ctrl #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned BIT_PERIOD      = 1,
    parameter logic        EVEN_PARITY_BIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  ser_data,
    output logic                  ser_en,
    output logic                  ser_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int unsigned IW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

`ifdef PARITY_TX_STOP_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`endif

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  acc_q, acc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  period_end;

    logic s_ready_q, s_ready_d;
    logic ser_data_q, ser_data_d;
    logic ser_en_q, ser_en_d;
    logic ser_last_q, ser_last_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;

    assign period_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    shreg_d = s_data;
                    acc_d   = EVEN_PARITY_BIT;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (period_end) begin
                    acc_d   = acc_q ^ shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = PARITY;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (period_end) begin
                    cnt_d = '0;
`ifdef PARITY_TX_STOP_EN
                    state_d = STOP;
`else
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef PARITY_TX_STOP_EN
            STOP: begin
                if (period_end) begin
                    cnt_d        = '0;
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the next-state values.
    always_comb begin
        ser_data_d = 1'b0;
        case (state_d)
            DATA:    ser_data_d = shreg_d[0];
            PARITY:  ser_data_d = acc_d;
`ifdef PARITY_TX_STOP_EN
            STOP:    ser_data_d = 1'b1;
`endif
            default: ser_data_d = 1'b0;
        endcase
        ser_en_d  = (state_d != IDLE) && (cnt_d == '0);
        busy_d    = (state_d != IDLE);
        s_ready_d = (state_d == IDLE);
`ifdef PARITY_TX_STOP_EN
        ser_last_d = (state_d == STOP);
`else
        ser_last_d = (state_d == PARITY);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            acc_q        <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            s_ready_q    <= 1'b1;
            ser_data_q   <= 1'b0;
            ser_en_q     <= 1'b0;
            ser_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            s_ready_q    <= s_ready_d;
            ser_data_q   <= ser_data_d;
            ser_en_q     <= ser_en_d;
            ser_last_q   <= ser_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign ser_data   = ser_data_q;
    assign ser_en     = ser_en_q;
    assign ser_last   = ser_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/parity_tx_ctrl.md
# parity_tx_ctrl

Frame sequencer for the serial parity path. Accepts a parallel word over a valid/ready handshake and shifts it out LSB-first as a serial bit stream with a write strobe, at a programmable bit period. After the data bits it appends the parity bit, which it computes on the fly. It sits between a word source and the serial sink that the shift-register/parity-generator pair currently models, and replaces the free-running pattern generator with a controlled, framed source.

## Interface
- DATA_WIDTH, 8, bits per word; must be ≥1.
- BIT_PERIOD, 1, clock cycles per serial bit; must be ≥1.
- EVEN_PARITY_BIT, 1'b0, parity polarity: parity = (^word) ^ EVEN_PARITY_BIT.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  DATA_WIDTH  word to transmit; sampled at handshake.
- s_valid  in  1  source has a word.
- s_ready  out  1  controller can accept; high only in IDLE.
- ser_data  out  1  current serial bit (data or parity).
- ser_en  out  1  strobe, high on the first cycle of each bit period.
- ser_last  out  1  high for the whole final bit period of a frame.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse after a frame completes.

## Operation
- States: IDLE, DATA, PARITY, and STOP (STOP exists only with the macro).
- IDLE: s_ready=1. When s_valid&&s_ready is true at an edge, the block latches s_data into the shift register, sets acc=EVEN_PARITY_BIT, sets bit_idx=0, sets period_cnt=0, and moves to DATA.
- DATA: ser_data = shreg[0]. period_cnt counts 0..BIT_PERIOD-1.
  - At the end of a period: acc ^= shreg[0], shreg >>= 1, bit_idx++.
  - After DATA_WIDTH bits, move to PARITY.
- PARITY: ser_data = acc for one bit period.
  - Without the macro: ser_last=1 in this state, and the block then returns to IDLE.
- All outputs are registered. The counter width is $clog2(BIT_PERIOD), with a minimum of 1. bit_idx is $clog2(DATA_WIDTH+1) bits wide.
- s_valid is ignored while busy. s_data may change freely outside the handshake edge.
- Reset values: s_ready=1; ser_data, ser_en, ser_last, busy and frame_done all 0; state=IDLE; shreg and acc cleared.
- Reset mid-frame: the frame is aborted immediately and all outputs take their reset values. No frame_done is issued. The first frame after release is sent cleanly.

## Timing
Let t0 be the handshake edge, W=DATA_WIDTH and B=BIT_PERIOD.
- Bit i (0..W-1) occupies cycles t0+1+i·B through t0+(i+1)·B.
- ser_en is high only in cycle t0+1+i·B.
- The parity bit occupies cycles t0+1+W·B through t0+(W+1)·B.
- At cycle t0+(W+1)·B+1 (F = t0+(W+1)·B+1 without the macro):
  - state=IDLE, s_ready=1, busy=0;
  - frame_done=1 for exactly this one cycle;
  - ser_data=0 and ser_en=0.
- Back-to-back: if s_valid is held high, the next handshake occurs at the edge ending cycle F. The inter-frame gap is therefore exactly one idle cycle.
- When B=1, ser_en is high on every cycle of the frame.

## Configuration
- PARITY_TX_STOP_EN defined:
  - After PARITY the block enters STOP for one bit period, with ser_data=1 and ser_en strobed.
  - ser_last moves from PARITY to STOP.
  - Frame length is (W+2)·B, and frame_done fires at t0+(W+2)·B+1.
- Not defined: the STOP state and its logic are absent, and the frame is W+1 bits.

## Test plan
- W=4, B=1, EVEN=0, s_data=4'b1001 → ser_data sequence 1,0,0,1,0. ser_en is high for 5 consecutive cycles. ser_last is high on the 5th. frame_done occurs at t0+6.
- W=4, B=1, s_data=4'b1011: EVEN=0 → parity bit 1; EVEN=1 → parity bit 0.
- W=4, B=3, s_data=4'b0110 → each bit is held for 3 cycles, with ser_en only at t0+1, t0+4, t0+7, t0+10 and t0+13 (parity 0). frame_done occurs at t0+16.
- s_valid held high with words 8'hA5 then 8'h01, default parameters:
  - Frame 1 gives parity 0; frame 2 gives parity 1.
  - Frame 2 starts exactly one cycle after frame_done.
  - s_ready is low throughout both frames.
- rst_n is asserted at bit 2 of a frame → all outputs drop to reset values asynchronously and no frame_done is issued. After release, 4'b1001 transmits correctly.
- With PARITY_TX_STOP_EN, W=4, B=1, s_data=4'b1001 → sequence 1,0,0,1,0,1. ser_last is on the 6th bit. frame_done occurs at t0+7.
